// File: rtl/bomb_game_sched_if.sv
// Signal bundle tying the game input stream, the cell-clearing engine and the result sink
// to the sequencer. The slave modport is the sequencer's view of the bundle.
interface bomb_game_sched_if #(
  parameter int ROWS  = 8,
  parameter int OUT_W = 7
);
  localparam int RW = $clog2(ROWS);

  logic            in_valid1;
  logic [ROWS-1:0] in;
  logic [ROWS-1:0] bomb;
  logic            in_valid2;
  logic [2*RW-1:0] hit;

  logic            ld_we;
  logic [RW-1:0]   ld_row;
  logic [ROWS-1:0] ld_map;
  logic [ROWS-1:0] ld_bomb;

  logic            eng_req;
  logic [2*RW-1:0] eng_hit;
  logic            eng_ack;
  logic [3:0]      eng_cleared;

  logic            out_valid;
  logic [OUT_W-1:0] out;

  modport master (
    output in_valid1, in, bomb, in_valid2, hit, eng_ack, eng_cleared,
    input  ld_we, ld_row, ld_map, ld_bomb, eng_req, eng_hit, out_valid, out
  );

  modport slave (
    input  in_valid1, in, bomb, in_valid2, hit, eng_ack, eng_cleared,
    output ld_we, ld_row, ld_map, ld_bomb, eng_req, eng_hit, out_valid, out
  );
endinterface

// File: rtl/bomb_game_sched.sv
// Runs one bomb game: streams map/bomb rows to the engine loader, buffers the hits,
// issues them one per req/ack exchange and pulses the summed cleared-cell count.
module bomb_game_sched #(
  parameter int ROWS     = 8,
  parameter int NUM_HITS = 10,
  parameter int OUT_W    = 7
) (
  input logic              clk,
  input logic              rst,
  bomb_game_sched_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int HW = 2 * RW;
  localparam int PW = $clog2(NUM_HITS);
  localparam int CW = $clog2(NUM_HITS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [HW-1:0]    fifo [NUM_HITS];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    acks;
  logic [RW-1:0]    row_idx;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] acc_nxt;
  logic             row_take;
  logic             issue;
  logic             accept;
  logic             last_ack;
  logic             push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NUM_HITS - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    row_take  = 1'b0;
    issue     = 1'b0;
    accept    = 1'b0;
    last_ack  = (acks == CW'(NUM_HITS - 1));
    case (state)
      IDLE, LOAD: begin
        if (bus.in_valid1) begin
          row_take  = 1'b1;
          state_nxt = (row_idx == RW'(ROWS - 1)) ? ISSUE : LOAD;
        end
      end
      ISSUE: begin
        if (count != '0) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // eng_req is always high here, so acks seen in any other state are ignored
        if (bus.eng_ack) begin
          accept    = 1'b1;
          state_nxt = last_ack ? DONE : ISSUE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign push    = bus.in_valid2 && (state != DONE) && (count != CW'(NUM_HITS));
  assign acc_nxt = acc + OUT_W'(bus.eng_cleared);

  always_ff @(posedge clk) begin
    if (rst) begin
      row_idx <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      acks    <= '0;
      acc     <= '0;
      for (int i = 0; i < NUM_HITS; i++) fifo[i] <= '0;
      bus.ld_we     <= 1'b0;
      bus.ld_row    <= '0;
      bus.ld_map    <= '0;
      bus.ld_bomb   <= '0;
      bus.eng_req   <= 1'b0;
      bus.eng_hit   <= '0;
      bus.out_valid <= 1'b0;
      bus.out       <= '0;
    end else begin
      bus.ld_we <= row_take;
      if (row_take) begin
        bus.ld_row  <= row_idx;
        bus.ld_map  <= bus.in;
        bus.ld_bomb <= bus.bomb;
        row_idx     <= row_idx + RW'(1);
      end

      if (push) begin
        fifo[wr_ptr] <= bus.hit;
        wr_ptr       <= ptr_inc(wr_ptr);
      end
      if (accept) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(push) - CW'(accept);

      // The ISSUE cycle doubles as the mandatory low gap on eng_req between hits
      if (issue) begin
        bus.eng_req <= 1'b1;
        bus.eng_hit <= fifo[rd_ptr];
      end
      if (accept) begin
        bus.eng_req <= 1'b0;
        acc         <= acc_nxt;
        acks        <= acks + CW'(1);
      end

      bus.out_valid <= accept && last_ack;
      bus.out       <= (accept && last_ack) ? acc_nxt : '0;

      if (state == DONE) begin
        row_idx <= '0;
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        acks    <= '0;
        acc     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bomb_game_sched.sv
// Bench for bomb_game_sched: table-driven games, a mid-game reset sequence and random games,
// with an engine model that clears cells from the loaded rows and a stimulus-side score model.
module tb_bomb_game_sched;
  typedef logic [7:0][7:0] grid_t;
  typedef logic [9:0][5:0] hits_t;
  typedef struct {
    grid_t map;
    grid_t bomb;
    hits_t hits;
    int    max_dly;
    bit    spurious;
    bit    extra;
    int    exp_total;
  } game_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bomb_game_sched_if bus ();
  bomb_game_sched dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0;
  int checks = 0;

  grid_t       cur_map, cur_bomb, eng_map, eng_bomb;
  logic [5:0]  exp_hits[$];
  logic [5:0]  held_hit;
  int          ld_cnt, acks_seen, pulses, first_req, last_ack_cyc, ack10_cyc;
  int          dly, max_dly, cur_exp;
  bit          busy, spur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One hit: an empty cell clears nothing, a plain cell clears itself,
  // a bomb clears every occupied cell of its 3x3 neighbourhood.
  function automatic int hit_clear(inout grid_t m, input grid_t bm, input logic [5:0] h);
    int r, c, n;
    r = int'(h[5:3]);
    c = int'(h[2:0]);
    n = 0;
    if (!m[r][c]) return 0;
    if (!bm[r][c]) begin
      m[r][c] = 1'b0;
      return 1;
    end
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8 && m[r + dr][c + dc]) begin
          m[r + dr][c + dc] = 1'b0;
          n++;
        end
    return n;
  endfunction

  function automatic int ref_total(input grid_t m, input grid_t bm, input hits_t hs);
    grid_t w;
    int s;
    w = m;
    s = 0;
    for (int i = 0; i < 10; i++) s += hit_clear(w, bm, hs[i]);
    return s;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, ".ld_we"},     bus.ld_we,     0);
    chk({tag, ".ld_row"},    bus.ld_row,    0);
    chk({tag, ".ld_map"},    bus.ld_map,    0);
    chk({tag, ".ld_bomb"},   bus.ld_bomb,   0);
    chk({tag, ".eng_req"},   bus.eng_req,   0);
    chk({tag, ".eng_hit"},   bus.eng_hit,   0);
    chk({tag, ".out_valid"}, bus.out_valid, 0);
    chk({tag, ".out"},       bus.out,       0);
  endtask

  // Called once per cycle at the falling edge: checks outputs and plays the engine.
  task automatic monitor(input int cyc);
    if (bus.ld_we) begin
      chk("ld_row", bus.ld_row, ld_cnt % 8);
      if (ld_cnt < 8) begin
        chk("ld_map",  bus.ld_map,  cur_map[ld_cnt]);
        chk("ld_bomb", bus.ld_bomb, cur_bomb[ld_cnt]);
      end
      eng_map[bus.ld_row]  = bus.ld_map;
      eng_bomb[bus.ld_row] = bus.ld_bomb;
      ld_cnt++;
    end
    if (!bus.out_valid) chk("out_idle_zero", bus.out, 0);
    else begin
      pulses++;
      if (pulses == 1) begin
        chk("out_total", bus.out, cur_exp);
        chk("out_after_ack10", cyc, ack10_cyc + 1);
        chk("out_deadline", (cyc - 7 <= 100), 1);
      end
    end
    bus.eng_ack     = 1'b0;
    bus.eng_cleared = 4'd0;
    if (bus.eng_req) begin
      if (!busy) begin
        busy     = 1'b1;
        held_hit = bus.eng_hit;
        dly      = $urandom_range(max_dly, 0);
        if (first_req < 0) begin
          first_req = cyc;
          chk("first_req_latency", cyc, 9);
        end
        if (exp_hits.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_req: request for hit %0d, none outstanding", bus.eng_hit);
        end else chk("hit_order", bus.eng_hit, exp_hits.pop_front());
      end else chk("hit_stable", bus.eng_hit, held_hit);
      if (dly == 0) begin
        bus.eng_ack     = 1'b1;
        bus.eng_cleared = 4'(hit_clear(eng_map, eng_bomb, held_hit));
        busy            = 1'b0;
        acks_seen++;
        last_ack_cyc = cyc;
        if (acks_seen == 10) ack10_cyc = cyc;
      end else dly--;
    end else begin
      busy = 1'b0;
      if (spur && $urandom_range(3, 0) == 0) begin
        bus.eng_ack     = 1'b1;
        bus.eng_cleared = 4'd9;
      end
    end
  endtask

  task automatic run_game(input game_t g, input int abort_at);
    bit finished, aborted;
    int rst_cyc;
    finished = 1'b0;
    aborted  = 1'b0;
    rst_cyc  = -10;
    cur_map  = g.map;
    cur_bomb = g.bomb;
    eng_map  = '0;
    eng_bomb = '0;
    exp_hits.delete();
    for (int i = 0; i < 10; i++) exp_hits.push_back(g.hits[i]);
    ld_cnt = 0; acks_seen = 0; pulses = 0; first_req = -1;
    last_ack_cyc = -10; ack10_cyc = -10;
    busy = 1'b0; max_dly = g.max_dly; spur = g.spurious; cur_exp = g.exp_total;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge clk);
      if (cyc == rst_cyc + 1) begin
        chk_zero("abort_rst");
        rst = 1'b0;
      end
      monitor(cyc);
      if (!aborted && pulses > 0 && !bus.out_valid) finished = 1'b1;
      if (aborted && cyc >= rst_cyc + 30) finished = 1'b1;
      bus.in_valid1 = (cyc < 8) || (g.spurious && cyc == 8) ||
                      (g.spurious && acks_seen == 10 && cyc == last_ack_cyc);
      bus.in        = (cyc < 8) ? g.map[cyc % 8]  : 8'hA5;
      bus.bomb      = (cyc < 8) ? g.bomb[cyc % 8] : 8'h5A;
      bus.in_valid2 = (cyc < 10) || (g.extra && cyc == 10);
      bus.hit       = (cyc < 10) ? g.hits[cyc % 10] : 6'd9;
      if (abort_at > 0 && !aborted && acks_seen == abort_at && cyc == last_ack_cyc + 1) begin
        rst     = 1'b1;
        aborted = 1'b1;
        rst_cyc = cyc;
      end
      if (aborted) begin
        bus.in_valid1 = 1'b0;
        bus.in_valid2 = 1'b0;
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL game_timeout: no completion within 400 cycles (pulses=%0d acks=%0d)",
               pulses, acks_seen);
    end
    if (aborted) chk("abort_no_pulse", pulses, 0);
    else begin
      chk("out_pulse_count", pulses, 1);
      chk("ld_we_count", ld_cnt, 8);
      chk("ack_count", acks_seen, 10);
      chk("hits_unissued", exp_hits.size(), 0);
    end
  endtask

  initial begin
    game_t tbl[4];
    game_t rg;
    hits_t plan_hits;
    int    plan[10] = '{0, 7, 56, 63, 4, 60, 24, 23, 1, 25};

    for (int i = 0; i < 10; i++) plan_hits[i] = 6'(plan[i]);
    tbl[0] = '{map: '0, bomb: '0, hits: plan_hits, max_dly: 0, spurious: 0, extra: 0, exp_total: 0};
    tbl[1] = '{map: '1, bomb: '1, hits: plan_hits, max_dly: 0, spurious: 0, extra: 0, exp_total: 38};
    tbl[2] = '{map: '1, bomb: '1, hits: plan_hits, max_dly: 5, spurious: 1, extra: 1, exp_total: 38};
    tbl[3] = '{map: '1, bomb: '0, hits: plan_hits, max_dly: 2, spurious: 1, extra: 0, exp_total: 10};

    bus.in_valid1 = 1'b0; bus.in = '0; bus.bomb = '0;
    bus.in_valid2 = 1'b0; bus.hit = '0;
    bus.eng_ack = 1'b0; bus.eng_cleared = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_game(tbl[i], 0);

    // Reset after the 5th ack, then a clean game must still score correctly
    run_game(tbl[1], 5);
    run_game(tbl[1], 0);

    for (int n = 0; n < 1000; n++) begin
      for (int r = 0; r < 8; r++) begin
        rg.map[r]  = 8'($urandom);
        rg.bomb[r] = 8'($urandom);
      end
      for (int i = 0; i < 10; i++) rg.hits[i] = 6'($urandom);
      rg.max_dly   = $urandom_range(3, 0);
      rg.spurious  = 1'($urandom);
      rg.extra     = 1'($urandom);
      rg.exp_total = ref_total(rg.map, rg.bomb, rg.hits);
      run_game(rg, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
